// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU port, aux port and data-memory signals of the data-memory arbiter.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  c_req;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_gnt;
    logic                  c_rvalid;
    logic [DATA_WIDTH-1:0] c_rdata;
    logic                  cpu_stall;

    logic                  x_req;
    logic                  x_we;
    logic                  x_lock;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [DATA_WIDTH-1:0] x_wdata;
    logic                  x_gnt;
    logic                  x_rvalid;
    logic [DATA_WIDTH-1:0] x_rdata;

    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, cpu_stall,
        input  x_req, x_we, x_lock, x_addr, x_wdata,
        output x_gnt, x_rvalid, x_rdata,
        output mem_a, mem_we, mem_wd,
        input  mem_rd
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, cpu_stall,
        output x_req, x_we, x_lock, x_addr, x_wdata,
        input  x_gnt, x_rvalid, x_rdata,
        input  mem_a, mem_we, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-port data memory between the CPU (C) and an aux master (X); optional DMEM_ARB_ROUND_ROBIN_EN.
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a requester holds its request until granted; the CPU sees cpu_stall while denied.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {ARB, X_BURST} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_t                state;
    logic [3:0]            starve_cnt;
    logic                  rsp_c;
    logic                  rsp_x;
    logic                  burst_hold;
    logic                  c_gnt;
    logic                  x_gnt;
    logic [ADDR_WIDTH-1:0] a_mux;
    logic [DATA_WIDTH-1:0] wd_mux;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic                  last_x;   // 1: X was granted most recently
`endif

    // A held lock keeps ownership with X; the cycle lock drops is arbitrated normally.
    assign burst_hold = (state == X_BURST) && bus.x_lock;

    always_comb begin
        c_gnt = 1'b0;
        x_gnt = 1'b0;
        if (rst) begin
            c_gnt = 1'b0;
            x_gnt = 1'b0;
        end else if (burst_hold) begin
            x_gnt = bus.x_req;
        end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (bus.c_req && bus.x_req) begin
                c_gnt = last_x;
                x_gnt = !last_x;
            end else begin
                c_gnt = bus.c_req;
                x_gnt = bus.x_req;
            end
`else
            if (bus.x_req && (starve_cnt == LIMIT)) begin
                x_gnt = 1'b1;
            end else if (bus.c_req) begin
                c_gnt = 1'b1;
            end else begin
                x_gnt = bus.x_req;
            end
`endif
        end
    end

    always_comb begin
        a_mux  = '0;
        wd_mux = '0;
        if (c_gnt) begin
            a_mux  = bus.c_addr;
            wd_mux = bus.c_wdata;
        end else if (x_gnt) begin
            a_mux  = bus.x_addr;
            wd_mux = bus.x_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= 4'd0;
            rsp_c      <= 1'b0;
            rsp_x      <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_x     <= 1'b1;
`endif
        end else begin
            if (bus.x_lock && (x_gnt || state == X_BURST)) begin
                state <= X_BURST;
            end else begin
                state <= ARB;
            end

            rsp_c <= c_gnt && !bus.c_we;
            rsp_x <= x_gnt && !bus.x_we;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
            starve_cnt <= 4'd0;
            if (c_gnt) begin
                last_x <= 1'b0;
            end else if (x_gnt) begin
                last_x <= 1'b1;
            end
`else
            if (x_gnt || !bus.x_req) begin
                starve_cnt <= 4'd0;
            end else if (c_gnt && starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
`endif
        end
    end

    assign bus.c_gnt     = c_gnt;
    assign bus.x_gnt     = x_gnt;
    assign bus.cpu_stall = bus.c_req && !c_gnt && !rst;

    // Response flags are masked during reset so a pending read never surfaces.
    assign bus.c_rvalid  = rsp_c && !rst;
    assign bus.x_rvalid  = rsp_x && !rst;
    assign bus.c_rdata   = bus.c_rvalid ? bus.mem_rd : '0;
    assign bus.x_rdata   = bus.x_rvalid ? bus.mem_rd : '0;

    assign bus.mem_a     = a_mux;
    assign bus.mem_wd    = wd_mux;
    assign bus.mem_we    = (c_gnt && bus.c_we) || (x_gnt && bus.x_we);
endmodule
